// File: rtl/motor_pkg.sv
// Shared motor-drive definitions: leg state encoding, phase bit positions and leg pair codes.
package motor_pkg;

  // Encoding equals the gate pair a leg drives in that state.
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON_L = 2'b01,
    ST_ON_H = 2'b10
  } leg_state_e;

  localparam int A_POS = 5;
  localparam int A_NEG = 4;
  localparam int B_POS = 3;
  localparam int B_NEG = 2;
  localparam int C_POS = 1;
  localparam int C_NEG = 0;

  localparam logic [1:0] LEG_OFF = 2'b00;
  localparam logic [1:0] LEG_LO  = 2'b01;
  localparam logic [1:0] LEG_HI  = 2'b10;
  localparam logic [1:0] LEG_BAD = 2'b11;

  function automatic logic leg_is_bad(input logic [1:0] pair);
    return (pair == LEG_BAD);
  endfunction

  function automatic logic [1:0] state_to_gate(input leg_state_e st);
    case (st)
      ST_ON_H: return 2'b10;
      ST_ON_L: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/leg_deadtime.sv
// One half-bridge leg: decodes the {p,n} command, enforces dead time and drives two
// registered gate bits that can never both be high.
module leg_deadtime
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pair,
  input  logic       pwm_on,
  output logic [1:0] gate
);

  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEAD_MAX = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  leg_state_e       target_s;
  leg_state_e       state_r;
  leg_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [1:0]       gate_r;

  // Target decode; an illegal 11 pair is treated as OFF.
  always_comb begin
    target_s = ST_OFF;
    case (pair)
      LEG_HI: begin
        if (pwm_on) target_s = ST_ON_H;
        else        target_s = ST_OFF;
      end
      LEG_LO:  target_s = ST_ON_L;
      default: target_s = ST_OFF;
    endcase
  end

  // Leg FSM. The dead counter restarts whenever nothing is requested, so every turn-on,
  // including each PWM chop pulse, follows DEAD_CYCLES of requested-but-off time.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    if (!enable) begin
      state_nx_s = ST_OFF;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (target_s == ST_OFF) begin
            cnt_nx_s = CNT_ZERO;
          end else if (cnt_r == DEAD_MAX) begin
            state_nx_s = target_s;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_ON_H, ST_ON_L: begin
          if (target_s != state_r) begin
            state_nx_s = ST_OFF;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: begin
          state_nx_s = ST_OFF;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, dead counter and gate registers; gates follow the next state to save a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OFF;
      cnt_r   <= CNT_ZERO;
      gate_r  <= 2'b00;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      gate_r  <= state_to_gate(state_nx_s);
    end
  end

  assign gate = gate_r;

endmodule

// File: rtl/pwm_deadtime_gate.sv
// Three-phase gate driver: synchronises the commutation command, chops the high sides with
// a fixed-period PWM and hands each leg to a dead-time controller.
module pwm_deadtime_gate
  import motor_pkg::*;
#(
  parameter int PWM_W       = 12,
  parameter int DEAD_CYCLES = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [5:0]       phase_cmd,
  input  logic [PWM_W-1:0] duty,
  output logic [5:0]       gate,
  output logic             pwm_sync,
  output logic             fault
);

  localparam logic [PWM_W-1:0] CNT_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] CNT_ZERO = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(1'b1);

  logic [SYNC_STAGES-1:0][5:0] sync_r;
  logic [5:0]                  cmd_s;
  logic [PWM_W-1:0]            cnt_r;
  logic [PWM_W-1:0]            duty_q_r;
  logic                        pwm_on_s;
  logic                        pwm_sync_r;
  logic                        fault_r;
  logic                        bad_s;

  assign cmd_s    = sync_r[SYNC_STAGES-1];
  assign pwm_on_s = (cnt_r < duty_q_r);
  assign bad_s    = leg_is_bad(cmd_s[A_POS:A_NEG]) | leg_is_bad(cmd_s[B_POS:B_NEG])
                  | leg_is_bad(cmd_s[C_POS:C_NEG]);

  // Command synchroniser from the commutation clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_r <= {(SYNC_STAGES*6){1'b0}};
    else        sync_r <= {sync_r[SYNC_STAGES-2:0], phase_cmd};
  end

  // PWM counter, period-aligned duty latch and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= CNT_ZERO;
      duty_q_r   <= CNT_ZERO;
      pwm_sync_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_r + CNT_ONE;
      pwm_sync_r <= (cnt_r == CNT_MAX);
      if (cnt_r == CNT_MAX) duty_q_r <= duty;
      else                  duty_q_r <= duty_q_r;
    end
  end

  // Sticky illegal-command flag, cleared only by disabling the drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fault_r <= 1'b0;
    else if (!enable) fault_r <= 1'b0;
    else if (bad_s)   fault_r <= 1'b1;
    else              fault_r <= fault_r;
  end

  leg_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pair(cmd_s[A_POS:A_NEG]),
    .pwm_on(pwm_on_s), .gate(gate[A_POS:A_NEG])
  );

  leg_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pair(cmd_s[B_POS:B_NEG]),
    .pwm_on(pwm_on_s), .gate(gate[B_POS:B_NEG])
  );

  leg_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pair(cmd_s[C_POS:C_NEG]),
    .pwm_on(pwm_on_s), .gate(gate[C_POS:C_NEG])
  );

  assign pwm_sync = pwm_sync_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_pwm_deadtime_gate.sv
// Self-checking bench for pwm_deadtime_gate: directed scenarios plus randomised commands,
// compared cycle by cycle with a behavioural model.
module tb_pwm_deadtime_gate;

  localparam int PWM_W  = 12;
  localparam int DEAD   = 50;
  localparam int SYNC   = 2;
  localparam int PERIOD = 1 << PWM_W;
  localparam int MAXC   = PERIOD - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [5:0]       phase_cmd = 6'b000000;
  logic [PWM_W-1:0] duty = 12'd0;
  logic [5:0]       gate;
  logic             pwm_sync;
  logic             fault;

  always #5 clk = ~clk;

  pwm_deadtime_gate #(.PWM_W(PWM_W), .DEAD_CYCLES(DEAD), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .phase_cmd(phase_cmd),
    .duty(duty), .gate(gate), .pwm_sync(pwm_sync), .fault(fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: command delay queue, period position, per-leg drive direction
  // (0 none, 1 high, 2 low) and the off-time accumulated towards the requested direction.
  logic [5:0] m_cmdq[$];
  int         m_pos, m_duty_q;
  bit         m_sync, m_fault;
  int         m_dir[3];
  int         m_wait[3];
  int         off_run[3];
  logic [1:0] prev_pair[3];

  function automatic void model_reset();
    m_cmdq.delete();
    for (int i = 0; i < SYNC; i++) m_cmdq.push_back(6'b000000);
    m_pos = 0; m_duty_q = 0; m_sync = 1'b0; m_fault = 1'b0;
    for (int l = 0; l < 3; l++) begin
      m_dir[l] = 0; m_wait[l] = 0; off_run[l] = 0; prev_pair[l] = 2'b00;
    end
  endfunction

  function automatic logic [5:0] model_gate();
    logic [5:0] g = 6'b000000;
    for (int l = 0; l < 3; l++) begin
      if (m_dir[l] == 1)      g[5-2*l] = 1'b1;
      else if (m_dir[l] == 2) g[4-2*l] = 1'b1;
    end
    return g;
  endfunction

  function automatic void model_step();
    logic [5:0] cs;
    bit pon, bad;
    int pair, req;
    cs  = m_cmdq[0];
    pon = (m_pos < m_duty_q);
    bad = 1'b0;
    for (int l = 0; l < 3; l++) begin
      pair = int'(cs[(5-2*l) -: 2]);
      if (pair == 3) bad = 1'b1;
      req = (pair == 2) ? (pon ? 1 : 0) : ((pair == 1) ? 2 : 0);
      if (!enable) begin
        m_dir[l] = 0; m_wait[l] = 0;
      end else if (m_dir[l] != 0) begin
        if (req != m_dir[l]) begin m_dir[l] = 0; m_wait[l] = 0; end
      end else if (req == 0) begin
        m_wait[l] = 0;
      end else if (m_wait[l] >= DEAD) begin
        m_dir[l] = req;
      end else begin
        m_wait[l]++;
      end
    end
    m_fault = enable && (m_fault || bad);
    m_sync  = (m_pos == MAXC);
    if (m_pos == MAXC) m_duty_q = int'(duty);
    m_pos = (m_pos + 1) % PERIOD;
    m_cmdq.push_back(phase_cmd);
    void'(m_cmdq.pop_front());
  endfunction

  // One clock: predict, let the edge happen, sample on the falling edge and check.
  task automatic cycle();
    logic [1:0] pr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("outputs", 32'({gate, pwm_sync, fault}), 32'({model_gate(), m_sync, m_fault}));
    for (int l = 0; l < 3; l++) begin
      pr = gate[(5-2*l) -: 2];
      check_eq("no_shoot_through", 32'(pr == 2'b11), 32'd0);
      if (pr != 2'b00 && prev_pair[l] == 2'b00)
        check_eq("dead_before_on", 32'(off_run[l] >= DEAD), 32'd1);
      if (pr == 2'b00) off_run[l]++;
      else             off_run[l] = 0;
      prev_pair[l] = pr;
    end
  endtask

  task automatic run_until_gate(input string tag, input int idx, input logic val,
                                input int budget, output int n);
    n = 0;
    while (gate[idx] !== val && n < budget) begin
      cycle();
      n++;
    end
    if (gate[idx] !== val) check_eq({tag, "_timeout"}, 32'(gate[idx]), 32'(val));
  endtask

  task automatic measure_period(input int change_at, input logic [PWM_W-1:0] new_duty,
                                output int highs, output int len);
    int n = 0;
    while (pwm_sync !== 1'b1 && n < 2*PERIOD) begin
      cycle();
      n++;
    end
    check_eq("sync_found", 32'(pwm_sync), 32'd1);
    highs = int'(gate[5]);
    len   = 1;
    n     = 0;
    do begin
      if (len == change_at) duty = new_duty;
      cycle();
      n++;
      if (pwm_sync !== 1'b1) begin
        highs += int'(gate[5]);
        len++;
      end
    end while (pwm_sync !== 1'b1 && n < 2*PERIOD);
  endtask

  logic [5:0] cmd_tab[10] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010,
                              6'b000110, 6'b000000, 6'b110000, 6'b001100, 6'b000011};

  initial begin
    int n, highs, len, quiet;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_gate", 32'(gate), 32'd0);
    check_eq("rst_sync", 32'(pwm_sync), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);

    // First turn-on after release, then a full-duty period
    model_reset();
    enable = 1'b1; phase_cmd = 6'b100001; duty = 12'd4095;
    rst_n = 1'b1;
    run_until_gate("c_neg_rise", 0, 1'b1, 200, n);
    check_eq("c_neg_rise_cycle", 32'(n), 32'(DEAD + SYNC + 1));
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_high_duty4095", 32'(highs), 32'(4095 - DEAD));
    check_eq("period_len", 32'(len), 32'(PERIOD));

    // Commutation step: C- off, then B- on after the dead time
    phase_cmd = 6'b100100;
    run_until_gate("c_neg_fall", 0, 1'b0, 20, n);
    check_eq("c_neg_fall_cycle", 32'(n), 32'(SYNC + 1));
    run_until_gate("b_neg_rise", 2, 1'b1, 200, n);
    check_eq("b_neg_rise_gap", 32'(n), 32'(DEAD));

    // Duty 2048, then a mid-period change to 1024
    duty = 12'd2048;
    cycle();
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_high_duty2048", 32'(highs), 32'd1998);
    check_eq("sync_period", 32'(len), 32'(PERIOD));
    measure_period(100, 12'd1024, highs, len);
    check_eq("a_pos_high_old_duty", 32'(highs), 32'd1998);
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_high_duty1024", 32'(highs), 32'd974);

    // Illegal command: fault, sticky until enable drops
    phase_cmd = 6'b110000;
    cycle(); cycle();
    check_eq("fault_not_early", 32'(fault), 32'd0);
    cycle();
    check_eq("fault_set", 32'(fault), 32'd1);
    check_eq("a_gates_off_bad", 32'(gate[5:4]), 32'd0);
    phase_cmd = 6'b100001;
    repeat (10) cycle();
    check_eq("fault_sticky", 32'(fault), 32'd1);
    enable = 1'b0;
    cycle();
    check_eq("fault_cleared", 32'(fault), 32'd0);
    check_eq("gate_off_disabled", 32'(gate), 32'd0);

    // Disable during ON_H, re-enable dead time, small-duty suppression
    enable = 1'b1; duty = 12'd4095;
    run_until_gate("a_pos_on", 5, 1'b1, 3*PERIOD, n);
    enable = 1'b0;
    cycle();
    check_eq("disable_gate_next", 32'(gate), 32'd0);
    enable = 1'b1;
    quiet = 0;
    for (int i = 0; i < DEAD; i++) begin
      cycle();
      if (gate != 6'b000000) quiet++;
    end
    check_eq("reenable_quiet", 32'(quiet), 32'd0);
    duty = 12'(DEAD);
    cycle();
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_duty_eq_dead", 32'(highs), 32'd0);
    duty = 12'(DEAD + 1);
    cycle();
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_duty_dead_plus1", 32'(highs), 32'd1);
    duty = 12'd0;
    cycle();
    measure_period(-1, 12'd0, highs, len);
    check_eq("a_pos_duty_zero", 32'(highs), 32'd0);

    // Randomised commands, duties and enable drops against the model
    for (int k = 0; k < 30; k++) begin
      phase_cmd = cmd_tab[$urandom_range(0, 9)];
      duty      = 12'($urandom_range(0, 4095));
      enable    = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(20, 300)) cycle();
    end

    // Asynchronous reset between edges with gates on
    enable = 1'b1; phase_cmd = 6'b100001;
    run_until_gate("c_on_before_rst", 0, 1'b1, 400, n);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_gate", 32'(gate), 32'd0);
    check_eq("async_rst_sync", 32'(pwm_sync), 32'd0);
    check_eq("async_rst_fault", 32'(fault), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run_until_gate("c_neg_rise_after_rst", 0, 1'b1, 200, n);
    check_eq("c_neg_rise_after_rst_cycle", 32'(n), 32'(DEAD + SYNC + 1));
    repeat (100) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1);
  end

endmodule
